// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with frame-synchronous display update.
// Optional per-digit decimal point input when SSEG_DP_EN is defined.
module sseg_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  blank,
`ifdef SSEG_DP_EN
  input  logic [3:0]  dp,
`endif
  output logic        upd_pend,
  output logic [7:0]  PIN,
  output logic [3:0]  AN
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             upd_pend_q, upd_pend_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       pin_q, pin_d;

  logic             slot_end;
  logic             frame_end;
  logic             dp_bit;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    hex7 = 7'h7F;
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

`ifdef SSEG_DP_EN
  assign dp_bit = dp[idx_q];
`else
  assign dp_bit = 1'b0;
`endif

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign nibble    = disp_q[4*idx_q +: 4];

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    disp_d     = disp_q;
    shadow_d   = shadow_q;
    upd_pend_d = upd_pend_q;

    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // A write landing on the boundary goes straight to the display so it is not held a full frame.
    if (wr_en) begin
      shadow_d = wr_data;
      if (frame_end) begin
        disp_d     = wr_data;
        upd_pend_d = 1'b0;
      end else begin
        upd_pend_d = 1'b1;
      end
    end else if (frame_end && upd_pend_q) begin
      disp_d     = shadow_q;
      upd_pend_d = 1'b0;
    end

    if ((cnt_q < CNT_BLANK) || blank[idx_q]) begin
      an_d = 4'hF;
    end else begin
      an_d = ~(4'b0001 << idx_q);
    end

    pin_d = {~dp_bit, hex7(nibble)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      disp_q     <= 16'h0000;
      shadow_q   <= 16'h0000;
      upd_pend_q <= 1'b0;
      an_q       <= 4'hF;
      pin_q      <= 8'hFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      shadow_q   <= shadow_d;
      upd_pend_q <= upd_pend_d;
      an_q       <= an_d;
      pin_q      <= pin_d;
    end
  end

  assign upd_pend = upd_pend_q;
  assign AN       = an_q;
  assign PIN      = pin_q;

endmodule
